// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine with architectural HI/LO.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix in FIX.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   a_raw;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   mag;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;

   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   amag;
   logic [WIDTH-1:0]   bmag;
   logic [WIDTH:0]     msum;
   logic [WIDTH:0]     rsh;
   logic [WIDTH:0]     rdiff;

   assign a_neg = op[0] & a[WIDTH-1];
   assign b_neg = op[0] & b[WIDTH-1];
   assign amag  = a_neg ? (~a + 1'b1) : a;
   assign bmag  = b_neg ? (~b + 1'b1) : b;

   // mag holds the multiplicand for MULT and the divisor for DIV
   assign msum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, mag} : {(WIDTH+1){1'b0}});
   assign rsh   = {rem, quo[WIDTH-1]};
   assign rdiff = rsh - {1'b0, mag};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         is_div <= 1'b0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         a_raw  <= '0;
         acc    <= '0;
         mag    <= '0;
         quo    <= '0;
         rem    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  is_div <= op[1];
                  sa     <= a_neg;
                  sb     <= b_neg;
                  a_raw  <= a;
                  cnt    <= CW'(WIDTH - 1);
                  busy   <= 1'b1;
                  state  <= RUN;
                  if (op[1]) begin
                     mag <= bmag;
                     quo <= amag;
                     rem <= '0;
                  end else begin
                     mag <= amag;
                     acc <= {{WIDTH{1'b0}}, bmag};
                  end
               end else begin
                  if (hi_wr) hi <= wdata;
                  if (lo_wr) lo <= wdata;
               end
            end
            RUN: begin
               if (is_div) begin
                  if (!rdiff[WIDTH]) begin
                     rem <= rdiff[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= rsh[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= {msum, acc[WIDTH-1:1]};
               end
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - 1'b1;
            end
            FIX: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
               if (!is_div) begin
                  {hi, lo} <= (sa ^ sb) ? (~acc + 1'b1) : acc;
               end else if (mag == '0) begin
                  hi <= a_raw;
                  lo <= '1;
               end else begin
                  lo <= (sa ^ sb) ? (~quo + 1'b1) : quo;
                  hi <= sa ? (~rem + 1'b1) : rem;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
